mem_req_arbiter: RTL and testbench

Two-client request arbiter sitting directly upstream of the core's AXI read/write bridge. It merges instruction-fetch (read-only) and data-memory (read/write) requests into the bridge's single-outstanding r_ena/w_ena/addr interface, then steers the bridge's r_ready/w_ready/r_data back to the requesting client. Only one transaction is outstanding at a time. Data reads are flagged to bypass the bridge's one-line read buffer.

---
 rtl/mem_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges instruction-fetch and data-memory requests onto the
// single-outstanding read/write bridge interface and routes the responses back.
// Data accesses are flagged no_icache so they bypass the bridge's line buffer.
// All outputs come straight from registers.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_kill_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [MASK_WIDTH-1:0] mem_wmask_i,
  output logic                  mem_ack_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  r_ena_o,
  output logic                  w_ena_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic [MASK_WIDTH-1:0] w_mask_o,
  output logic                  no_icache_o,
  input  logic                  r_ready_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic                  w_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_IF_WAIT     = 3'd1,
    S_MEM_RD_WAIT = 3'd2,
    S_MEM_WR_WAIT = 3'd3,
    S_DONE        = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_kill_pend;
  logic                  w_kill_pend_nxt;

  logic                  r_if_ack;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic                  r_mem_ack;
  logic [DATA_WIDTH-1:0] r_mem_rdata;
  logic                  r_r_ena;
  logic                  r_w_ena;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic                  r_no_icache;

  logic                  w_if_ack;
  logic [DATA_WIDTH-1:0] w_if_rdata;
  logic                  w_mem_ack;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic                  w_r_ena;
  logic                  w_w_ena;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [MASK_WIDTH-1:0] w_wmask;
  logic                  w_no_icache;

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign r_ena_o     = r_r_ena;
  assign w_ena_o     = r_w_ena;
  assign addr_o      = r_addr;
  assign w_data_o    = r_wdata;
  assign w_mask_o    = r_wmask;
  assign no_icache_o = r_no_icache;

  // State register plus registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_kill_pend <= 1'b0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= {DATA_WIDTH{1'b0}};
      r_mem_ack   <= 1'b0;
      r_mem_rdata <= {DATA_WIDTH{1'b0}};
      r_r_ena     <= 1'b0;
      r_w_ena     <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_wmask     <= {MASK_WIDTH{1'b0}};
      r_no_icache <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_kill_pend <= w_kill_pend_nxt;
      r_if_ack    <= w_if_ack;
      r_if_rdata  <= w_if_rdata;
      r_mem_ack   <= w_mem_ack;
      r_mem_rdata <= w_mem_rdata;
      r_r_ena     <= w_r_ena;
      r_w_ena     <= w_w_ena;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wmask     <= w_wmask;
      r_no_icache <= w_no_icache;
    end
  end

  // Next-state and next-output logic: grant in IDLE, await bridge response in WAIT.
  always_comb begin
    w_state_nxt     = r_state;
    w_kill_pend_nxt = r_kill_pend;
    w_if_ack        = 1'b0;
    w_mem_ack       = 1'b0;
    w_r_ena         = 1'b0;
    w_w_ena         = 1'b0;
    w_if_rdata      = r_if_rdata;
    w_mem_rdata     = r_mem_rdata;
    w_addr          = r_addr;
    w_wdata         = r_wdata;
    w_wmask         = r_wmask;
    w_no_icache     = r_no_icache;

    case (r_state)
      S_IDLE: begin
        // Data access wins: it belongs to an older instruction than the fetch.
        if (mem_req_i) begin
          w_addr      = mem_addr_i;
          w_wdata     = mem_wdata_i;
          w_wmask     = mem_wmask_i;
          w_no_icache = 1'b1;
          if (mem_we_i) begin
            w_w_ena     = 1'b1;
            w_state_nxt = S_MEM_WR_WAIT;
          end else begin
            w_r_ena     = 1'b1;
            w_state_nxt = S_MEM_RD_WAIT;
          end
        end else if (if_req_i && !if_kill_i) begin
          w_addr          = if_addr_i;
          w_wdata         = {DATA_WIDTH{1'b0}};
          w_wmask         = {MASK_WIDTH{1'b0}};
          w_no_icache     = 1'b0;
          w_r_ena         = 1'b1;
          w_kill_pend_nxt = 1'b0;
          w_state_nxt     = S_IF_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IF_WAIT: begin
        if (r_ready_i) begin
          // A flushed fetch still has to drain its bridge response, but silently.
          w_state_nxt     = S_DONE;
          w_kill_pend_nxt = 1'b0;
          if (!(r_kill_pend || if_kill_i)) begin
            w_if_ack   = 1'b1;
            w_if_rdata = r_data_i;
          end else begin
            w_if_ack = 1'b0;
          end
        end else if (if_kill_i) begin
          w_kill_pend_nxt = 1'b1;
        end else begin
          w_kill_pend_nxt = r_kill_pend;
        end
      end
      S_MEM_RD_WAIT: begin
        if (r_ready_i) begin
          w_mem_ack   = 1'b1;
          w_mem_rdata = r_data_i;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MEM_RD_WAIT;
        end
      end
      S_MEM_WR_WAIT: begin
        if (w_ready_i) begin
          w_mem_ack   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MEM_WR_WAIT;
        end
      end
      S_DONE: begin
        // One-cycle bubble so the acked client can drop its request first.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_kill_pend_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; inputs change 1 time unit
// after the rising edge, outputs are checked at that same point.
module tb_mem_req_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_kill_i = 1'b0;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          mem_req_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic [DW-1:0] mem_wdata_i = '0;
  logic [MW-1:0] mem_wmask_i = '0;
  logic          mem_ack_o;
  logic [DW-1:0] mem_rdata_o;
  logic          r_ena_o;
  logic          w_ena_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] w_data_o;
  logic [MW-1:0] w_mask_o;
  logic          no_icache_o;
  logic          r_ready_i = 1'b0;
  logic [DW-1:0] r_data_i = '0;
  logic          w_ready_i = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
    .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .r_ena_o(r_ena_o), .w_ena_o(w_ena_o), .addr_o(addr_o),
    .w_data_o(w_data_o), .w_mask_o(w_mask_o), .no_icache_o(no_icache_o),
    .r_ready_i(r_ready_i), .r_data_i(r_data_i), .w_ready_i(w_ready_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if ({if_ack_o, mem_ack_o, r_ena_o, w_ena_o, no_icache_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {if_ack_o, mem_ack_o, r_ena_o, w_ena_o, no_icache_o}); end
    checks++; if ({if_rdata_o, mem_rdata_o, addr_o, w_data_o, w_mask_o} !== '0) begin errors++; $display("FAIL reset_data: addr=%0h wdata=%0h mask=%0h ifr=%0h memr=%0h exp all 0", addr_o, w_data_o, w_mask_o, if_rdata_o, mem_rdata_o); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_if_read();
    if_req_i = 1'b1; if_addr_i = 64'h0000_0000_8000_0000;
    step();
    checks++; if (r_ena_o !== 1'b1 || w_ena_o !== 1'b0) begin errors++; $display("FAIL if_issue: r_ena=%b w_ena=%b exp 1 0", r_ena_o, w_ena_o); end
    checks++; if (addr_o !== 64'h0000_0000_8000_0000 || no_icache_o !== 1'b0) begin errors++; $display("FAIL if_addr: addr=%0h nc=%b exp 80000000 0", addr_o, no_icache_o); end
    step();
    checks++; if (r_ena_o !== 1'b0) begin errors++; $display("FAIL if_rena_pulse: got %b exp 0", r_ena_o); end
    step();
    r_ready_i = 1'b1; r_data_i = 64'h0000_0013_0000_0093;
    checks++; if (if_ack_o !== 1'b0) begin errors++; $display("FAIL if_early_ack: got %b exp 0", if_ack_o); end
    step();
    r_ready_i = 1'b0; if_req_i = 1'b0;
    checks++; if (if_ack_o !== 1'b1 || mem_ack_o !== 1'b0) begin errors++; $display("FAIL if_ack: if_ack=%b mem_ack=%b exp 1 0", if_ack_o, mem_ack_o); end
    checks++; if (if_rdata_o !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL if_rdata: got %0h exp 1300000093", if_rdata_o); end
    step();
    checks++; if (if_ack_o !== 1'b0 || r_ena_o !== 1'b0) begin errors++; $display("FAIL if_ack_pulse: ack=%b r_ena=%b exp 0 0", if_ack_o, r_ena_o); end
    step();
  endtask

  task automatic test_priority();
    if_req_i = 1'b1; if_addr_i = 64'h0000_0000_8000_0040;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 64'h0000_0000_8000_1000;
    mem_wdata_i = 64'h0000_0000_DEAD_BEEF; mem_wmask_i = 8'h0F;
    step();
    checks++; if (w_ena_o !== 1'b1 || r_ena_o !== 1'b0 || no_icache_o !== 1'b1) begin errors++; $display("FAIL pri_issue: w_ena=%b r_ena=%b nc=%b exp 1 0 1", w_ena_o, r_ena_o, no_icache_o); end
    checks++; if (addr_o !== 64'h0000_0000_8000_1000 || w_data_o !== 64'h0000_0000_DEAD_BEEF || w_mask_o !== 8'h0F) begin errors++; $display("FAIL pri_wr_fields: addr=%0h wdata=%0h mask=%0h exp 80001000 deadbeef f", addr_o, w_data_o, w_mask_o); end
    step();
    w_ready_i = 1'b1;
    checks++; if (w_ena_o !== 1'b0) begin errors++; $display("FAIL pri_wena_pulse: got %b exp 0", w_ena_o); end
    step();
    w_ready_i = 1'b0; mem_req_i = 1'b0;
    checks++; if (mem_ack_o !== 1'b1 || if_ack_o !== 1'b0) begin errors++; $display("FAIL pri_mem_ack: mem=%b if=%b exp 1 0", mem_ack_o, if_ack_o); end
    step();
    checks++; if (r_ena_o !== 1'b0 || mem_ack_o !== 1'b0) begin errors++; $display("FAIL pri_done_bubble: r_ena=%b mem_ack=%b exp 0 0", r_ena_o, mem_ack_o); end
    step();
    checks++; if (r_ena_o !== 1'b1 || addr_o !== 64'h0000_0000_8000_0040 || no_icache_o !== 1'b0) begin errors++; $display("FAIL pri_fetch_issue: r_ena=%b addr=%0h nc=%b exp 1 80000040 0", r_ena_o, addr_o, no_icache_o); end
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0AAA;
    step();
    r_ready_i = 1'b0; if_req_i = 1'b0;
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 64'h0000_0000_0000_0AAA) begin errors++; $display("FAIL pri_fetch_ack: ack=%b rdata=%0h exp 1 aaa", if_ack_o, if_rdata_o); end
    step(); step();
  endtask

  task automatic test_data_read();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h0000_0000_1000_0000;
    step();
    checks++; if (r_ena_o !== 1'b1 || no_icache_o !== 1'b1 || addr_o !== 64'h0000_0000_1000_0000) begin errors++; $display("FAIL drd_issue: r_ena=%b nc=%b addr=%0h exp 1 1 10000000", r_ena_o, no_icache_o, addr_o); end
    step();
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0055;
    step();
    r_ready_i = 1'b0; mem_req_i = 1'b0;
    checks++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 64'h55 || if_ack_o !== 1'b0) begin errors++; $display("FAIL drd_ack: mem_ack=%b rdata=%0h if_ack=%b exp 1 55 0", mem_ack_o, mem_rdata_o, if_ack_o); end
    checks++; if (if_rdata_o !== 64'h0000_0000_0000_0AAA) begin errors++; $display("FAIL drd_if_hold: got %0h exp aaa", if_rdata_o); end
    step();
    checks++; if (mem_ack_o !== 1'b0 || mem_rdata_o !== 64'h55) begin errors++; $display("FAIL drd_hold: ack=%b rdata=%0h exp 0 55", mem_ack_o, mem_rdata_o); end
    step();
  endtask

  task automatic test_kill();
    if_req_i = 1'b1; if_addr_i = 64'h0000_0000_8000_0080;
    step();
    checks++; if (r_ena_o !== 1'b1) begin errors++; $display("FAIL kill_issue: got %b exp 1", r_ena_o); end
    if_kill_i = 1'b1;
    step();
    if_kill_i = 1'b0;
    step();
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0BAD; if_req_i = 1'b0;
    step();
    r_ready_i = 1'b0;
    checks++; if (if_ack_o !== 1'b0 || if_rdata_o !== 64'h0000_0000_0000_0AAA) begin errors++; $display("FAIL kill_no_ack: ack=%b rdata=%0h exp 0 aaa", if_ack_o, if_rdata_o); end
    step();
    if_req_i = 1'b1; if_addr_i = 64'h0000_0000_8000_0100;
    step();
    checks++; if (r_ena_o !== 1'b1 || addr_o !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL kill_refetch: r_ena=%b addr=%0h exp 1 80000100", r_ena_o, addr_o); end
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_1111;
    step();
    r_ready_i = 1'b0; if_req_i = 1'b0;
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 64'h0000_0000_0000_1111) begin errors++; $display("FAIL kill_refetch_ack: ack=%b rdata=%0h exp 1 1111", if_ack_o, if_rdata_o); end
    step(); step();
  endtask

  task automatic test_stray();
    r_ready_i = 1'b1; w_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0EEE;
    step();
    r_ready_i = 1'b0; w_ready_i = 1'b0;
    checks++; if ({if_ack_o, mem_ack_o, r_ena_o, w_ena_o} !== 4'b0 || mem_rdata_o !== 64'h55) begin errors++; $display("FAIL stray_idle: ctrl=%b memr=%0h exp 0000 55", {if_ack_o, mem_ack_o, r_ena_o, w_ena_o}, mem_rdata_o); end
    if_req_i = 1'b1; if_addr_i = 64'h0000_0000_8000_0200;
    step();
    w_ready_i = 1'b1;
    checks++; if (r_ena_o !== 1'b1) begin errors++; $display("FAIL stray_issue: got %b exp 1", r_ena_o); end
    step();
    w_ready_i = 1'b0;
    checks++; if (if_ack_o !== 1'b0 || mem_ack_o !== 1'b0) begin errors++; $display("FAIL stray_wready: if=%b mem=%b exp 0 0", if_ack_o, mem_ack_o); end
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_2222;
    step();
    r_ready_i = 1'b0; if_req_i = 1'b0;
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 64'h0000_0000_0000_2222) begin errors++; $display("FAIL stray_still_wait: ack=%b rdata=%0h exp 1 2222", if_ack_o, if_rdata_o); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h0000_0000_1000_0008;
    step();
    mem_req_i = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if ({if_ack_o, mem_ack_o, r_ena_o, w_ena_o, no_icache_o} !== 5'b0 || addr_o !== '0 || mem_rdata_o !== '0 || if_rdata_o !== '0) begin errors++; $display("FAIL rmid_outputs: ctrl=%b addr=%0h memr=%0h ifr=%0h exp all 0", {if_ack_o, mem_ack_o, r_ena_o, w_ena_o, no_icache_o}, addr_o, mem_rdata_o, if_rdata_o); end
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0077;
    step();
    r_ready_i = 1'b0;
    checks++; if (mem_ack_o !== 1'b0 || mem_rdata_o !== '0) begin errors++; $display("FAIL rmid_late_resp: ack=%b rdata=%0h exp 0 0", mem_ack_o, mem_rdata_o); end
    mem_req_i = 1'b1; mem_addr_i = 64'h0000_0000_1000_0010;
    step();
    checks++; if (r_ena_o !== 1'b1 || addr_o !== 64'h0000_0000_1000_0010) begin errors++; $display("FAIL rmid_next_issue: r_ena=%b addr=%0h exp 1 10000010", r_ena_o, addr_o); end
    r_ready_i = 1'b1; r_data_i = 64'h0000_0000_0000_0099;
    step();
    r_ready_i = 1'b0; mem_req_i = 1'b0;
    checks++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 64'h99) begin errors++; $display("FAIL rmid_next_ack: ack=%b rdata=%0h exp 1 99", mem_ack_o, mem_rdata_o); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_data_read();
    test_kill();
    test_stray();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
